// File: rtl/lcd_read_port.sv
// HD44780-style read-cycle sequencer: RS/RW setup, timed E pulse, data capture on the
// last E-high cycle, optional busy-flag polling with a poll limit.
module lcd_read_port #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned E_HIGH_CYCLES = 4,
  parameter int unsigned E_LOW_CYCLES  = 4,
  parameter int unsigned POLL_LIMIT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_wait_busy,
  output logic       bus_owned,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       timeout,
  input  logic [7:0] lcd_data_in,
  output logic [1:0] lcd_ctrl,
  output logic       lcd_enable
);

  localparam int unsigned MAX_SH = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int unsigned MAXC   = (MAX_SH > E_LOW_CYCLES) ? MAX_SH : E_LOW_CYCLES;
  localparam int unsigned CW     = $clog2(MAXC + 1);
  localparam int unsigned PW     = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, E_LOW, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  poll_cnt;
  logic           wait_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      poll_cnt    <= '0;
      wait_mode   <= 1'b0;
      bus_owned   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      timeout     <= 1'b0;
      lcd_ctrl    <= 2'b00;
      lcd_enable  <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state     <= SETUP;
            cnt       <= '0;
            poll_cnt  <= '0;
            wait_mode <= req_wait_busy;
            lcd_ctrl  <= {req_rs & ~req_wait_busy, 1'b1};
            bus_owned <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            state      <= E_HIGH;
            cnt        <= '0;
            lcd_enable <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        E_HIGH: begin
          if (cnt == CW'(E_HIGH_CYCLES - 1)) begin
            state      <= E_LOW;
            cnt        <= '0;
            lcd_enable <= 1'b0;
            rdata      <= lcd_data_in;
            poll_cnt   <= poll_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        E_LOW: begin
          if (cnt == CW'(E_LOW_CYCLES - 1)) begin
            cnt <= '0;
            // rdata already holds this poll's byte, so the busy decision uses the registered copy
            if (wait_mode && rdata[7] && (poll_cnt < PW'(POLL_LIMIT))) begin
              state <= SETUP;
            end else begin
              state       <= DONE;
              rdata_valid <= 1'b1;
              timeout     <= wait_mode & rdata[7];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus_owned <= 1'b0;
          lcd_ctrl  <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_read_port.sv
// Self-checking bench for lcd_read_port: per-cycle expectations derived from
// poll count and timing arithmetic, with randomized data and modes.
module tb_lcd_read_port;

  localparam int S  = 2;
  localparam int H  = 4;
  localparam int L  = 4;
  localparam int T  = S + H + L;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       req_rs;
  logic       req_wait_busy;
  logic       bus_owned;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       timeout;
  logic [7:0] lcd_data_in;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;

  int checks   = 0;
  int failures = 0;
  logic [7:0] poll_data [8];
  logic [7:0] last_rdata;

  lcd_read_port #(
    .SETUP_CYCLES (S),
    .E_HIGH_CYCLES(H),
    .E_LOW_CYCLES (L),
    .POLL_LIMIT   (PL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_rs       (req_rs),
    .req_wait_busy(req_wait_busy),
    .bus_owned    (bus_owned),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .timeout      (timeout),
    .lcd_data_in  (lcd_data_in),
    .lcd_ctrl     (lcd_ctrl),
    .lcd_enable   (lcd_enable)
  );

  always #5 clk = ~clk;

  // Number of read cycles the transaction performs for the current poll_data
  function automatic int model_polls(input logic wb);
    for (int k = 0; k < 8; k++)
      if (!wb || !poll_data[k][7] || (k + 1) >= PL) return k + 1;
    return 8;
  endfunction

  // Issues one request and checks every cycle through the cycle after DONE.
  // Extra req pulses are driven at offsets inj_a/inj_b (-1 = none).
  task automatic run_read(input logic rs, input logic wb, input int inj_a, input int inj_b);
    int n, idx;
    logic       e_own, e_en, e_valid, e_tout;
    logic [1:0] e_ctrl;
    logic [7:0] e_rdata;
    n = model_polls(wb);
    req = 1'b1; req_rs = rs; req_wait_busy = wb; lcd_data_in = poll_data[0];
    @(posedge clk);
    for (int j = 0; j <= n * T + 1; j++) begin
      @(negedge clk);
      req = (j == inj_a) || (j == inj_b);
      req_rs = $urandom_range(0, 1);
      req_wait_busy = $urandom_range(0, 1);
      e_own   = (j <= n * T);
      e_en    = (j < n * T) && ((j % T) >= S) && ((j % T) < S + H);
      e_valid = (j == n * T);
      e_tout  = e_valid && wb && poll_data[n-1][7];
      e_ctrl  = e_own ? {rs & ~wb, 1'b1} : 2'b00;
      if (j >= S + H) begin
        idx = (j - S - H) / T;
        if (idx > n - 1) idx = n - 1;
        e_rdata = poll_data[idx];
      end else begin
        e_rdata = last_rdata;
      end
      checks += 6;
      if (bus_owned !== e_own) begin
        failures++; $display("FAIL bus_owned off=%0d got=%b exp=%b", j, bus_owned, e_own);
      end
      if (lcd_ctrl !== e_ctrl) begin
        failures++; $display("FAIL lcd_ctrl off=%0d got=%b exp=%b", j, lcd_ctrl, e_ctrl);
      end
      if (lcd_enable !== e_en) begin
        failures++; $display("FAIL lcd_enable off=%0d got=%b exp=%b", j, lcd_enable, e_en);
      end
      if (rdata_valid !== e_valid) begin
        failures++; $display("FAIL rdata_valid off=%0d got=%b exp=%b", j, rdata_valid, e_valid);
      end
      if (timeout !== e_tout) begin
        failures++; $display("FAIL timeout off=%0d got=%b exp=%b", j, timeout, e_tout);
      end
      if (rdata !== e_rdata) begin
        failures++; $display("FAIL rdata off=%0d got=%h exp=%h", j, rdata, e_rdata);
      end
      idx = j / T;
      if (idx > 7) idx = 7;
      lcd_data_in = poll_data[idx];
    end
    last_rdata = poll_data[n-1];
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; req_rs = 1'b0; req_wait_busy = 1'b0; lcd_data_in = 8'h5A;
    repeat (3) @(negedge clk);
    checks += 5;
    if (lcd_ctrl !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00", lcd_ctrl); end
    if (lcd_enable !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", lcd_enable); end
    if (bus_owned !== 1'b0) begin failures++; $display("FAIL reset_owned got=%b exp=0", bus_owned); end
    if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    if (rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rdata_valid); end
    rst = 1'b0;
    last_rdata = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_owned, lcd_ctrl, lcd_enable, rdata_valid, timeout, rdata} !== 14'h0) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d got=%b%b%b%b%b %h exp=all zero",
                 i, bus_owned, lcd_ctrl, lcd_enable, rdata_valid, timeout, rdata);
      end
    end
  endtask

  task automatic test_plain_read();
    poll_data[0] = 8'h41;
    run_read(1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_wait_busy();
    poll_data[0] = 8'h80; poll_data[1] = 8'h80; poll_data[2] = 8'h05;
    run_read(1'b1, 1'b1, -1, -1);
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 8; k++) poll_data[k] = 8'hFF;
    run_read(1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_busy_reject();
    poll_data[0] = 8'h3C;
    run_read(1'b0, 1'b0, S + 1, T);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_owned !== 1'b0 || rdata_valid !== 1'b0) begin
        failures++;
        $display("FAIL reject_idle cyc=%0d got owned=%b valid=%b exp=0 0", i, bus_owned, rdata_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    poll_data[0] = 8'h12;
    run_read(1'b1, 1'b0, -1, -1);
    poll_data[0] = 8'hA7;
    run_read(1'b0, 1'b0, T, -1);
    poll_data[0] = 8'h80; poll_data[1] = 8'h6E;
    run_read(1'b1, 1'b1, -1, -1);
  endtask

  task automatic test_reset_mid();
    poll_data[0] = 8'h99;
    req = 1'b1; req_rs = 1'b1; req_wait_busy = 1'b0; lcd_data_in = 8'h99;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    repeat (S + 1) @(negedge clk);
    checks++;
    if (lcd_enable !== 1'b1) begin failures++; $display("FAIL mid_pre_en got=%b exp=1", lcd_enable); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (lcd_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_en got=%b exp=0", lcd_enable); end
    if (bus_owned !== 1'b0) begin failures++; $display("FAIL mid_rst_owned got=%b exp=0", bus_owned); end
    if (lcd_ctrl !== 2'b00) begin failures++; $display("FAIL mid_rst_ctrl got=%b exp=00", lcd_ctrl); end
    if (rdata !== 8'h00) begin failures++; $display("FAIL mid_rst_rdata got=%h exp=00", rdata); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_rdata = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (rdata_valid !== 1'b0 || bus_owned !== 1'b0) begin
        failures++;
        $display("FAIL mid_rst_quiet cyc=%0d got valid=%b owned=%b exp=0 0", i, rdata_valid, bus_owned);
      end
    end
    poll_data[0] = 8'h27;
    run_read(1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    logic rs, wb;
    for (int it = 0; it < 20; it++) begin
      rs = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        poll_data[k] = 8'($urandom);
        if (wb) poll_data[k][7] = ($urandom_range(0, 2) != 0);
      end
      run_read(rs, wb, (it % 3 == 0) ? int'($urandom_range(0, T - 1)) : -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0; req_rs = 1'b0; req_wait_busy = 1'b0; lcd_data_in = 8'h00;
    last_rdata = 8'h00;
    for (int k = 0; k < 8; k++) poll_data[k] = 8'h00;
    test_reset();
    test_plain_read();
    test_wait_busy();
    test_timeout();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
